// File: rtl/collatz_pkg.sv
// Shared state encoding and status codes for the Collatz orbit engine.
package collatz_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_OVF      = 2'b01;
  localparam logic [1:0] ST_OLEN_SAT = 2'b10;
  localparam logic [1:0] ST_BAD_SEED = 2'b11;

endpackage

// File: rtl/collatz_step.sv
// One Collatz step: n/2 for even n, 3n+1 (or (3n+1)/2 in shortcut mode) for odd n.
module collatz_step #(
  parameter int BITS = 64
) (
  input  logic [BITS-1:0] iter_i,
  input  logic            mode_i,
  output logic [BITS-1:0] next_o,
  output logic            ovf_o
);

  logic [BITS+1:0] wide;
  logic [BITS+1:0] odd_res;
  logic [BITS+1:0] res;

  // Two guard bits hold 3n+1 for any BITS-wide n without wrap.
  assign wide    = ({2'b00, iter_i} << 1) + {2'b00, iter_i} + {{(BITS+1){1'b0}}, 1'b1};
  assign odd_res = mode_i ? (wide >> 1) : wide;
  assign res     = iter_i[0] ? odd_res : ({2'b00, iter_i} >> 1);

  assign next_o = res[BITS-1:0];
  assign ovf_o  = |res[BITS+1:BITS];

endmodule

// File: rtl/collatz_engine.sv
// Collatz orbit engine: start/done handshake, one step per clock, length/record/status.
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int BITS      = 64,
  parameter int OLEN_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BITS-1:0]      seed,
  input  logic                 mode,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [OLEN_BITS-1:0] orbit_len,
  output logic [BITS-1:0]      path_record,
  output logic [1:0]           status
);

  state_e                 state_q;
  logic [BITS-1:0]        iter_q;
  logic                   mode_q;
  logic                   busy_q;
  logic                   done_q;
  logic [OLEN_BITS-1:0]   olen_q;
  logic [BITS-1:0]        rec_q;
  logic [1:0]             status_q;

  logic [BITS-1:0]        step_d;
  logic                   step_ovf;

  collatz_step #(.BITS(BITS)) u_step (
    .iter_i (iter_q),
    .mode_i (mode_q),
    .next_o (step_d),
    .ovf_o  (step_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      olen_q   <= '0;
      rec_q    <= '0;
      status_q <= ST_OK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            iter_q   <= seed;
            mode_q   <= mode;
            olen_q   <= '0;
            rec_q    <= seed;
            status_q <= ST_OK;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          // Termination checks in priority order; only the last branch steps.
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (iter_q == '0 || iter_q == {{(BITS-1){1'b0}}, 1'b1} ||
                       step_ovf || (&olen_q)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
            if (iter_q == '0)                             status_q <= ST_BAD_SEED;
            else if (iter_q == {{(BITS-1){1'b0}}, 1'b1}) status_q <= ST_OK;
            else if (step_ovf)                            status_q <= ST_OVF;
            else                                          status_q <= ST_OLEN_SAT;
          end else begin
            iter_q <= step_d;
            olen_q <= olen_q + 1'b1;
            if (step_d > rec_q) rec_q <= step_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign orbit_len   = olen_q;
  assign path_record = rec_q;
  assign status      = status_q;

endmodule

// File: tb/tb_collatz_engine.sv
// Directed-vector bench for collatz_engine, plus narrow-width overflow/saturation instances.
module tb_collatz_engine;
  import collatz_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mode, abort;
  logic [63:0] seed;

  logic        busy, done;
  logic [15:0] orbit_len;
  logic [63:0] path_record;
  logic [1:0]  status;

  logic        busy8, done8;
  logic [15:0] olen8;
  logic [7:0]  rec8;
  logic [1:0]  st8;

  logic        busys, dones;
  logic [5:0]  olens;
  logic [63:0] recs;
  logic [1:0]  sts;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  collatz_engine #(.BITS(64), .OLEN_BITS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .mode(mode), .abort(abort),
    .busy(busy), .done(done), .orbit_len(orbit_len), .path_record(path_record), .status(status)
  );

  collatz_engine #(.BITS(8), .OLEN_BITS(16)) dut8 (
    .clk(clk), .reset(reset), .start(start), .seed(seed[7:0]), .mode(mode), .abort(abort),
    .busy(busy8), .done(done8), .orbit_len(olen8), .path_record(rec8), .status(st8)
  );

  collatz_engine #(.BITS(64), .OLEN_BITS(6)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .mode(mode), .abort(abort),
    .busy(busys), .done(dones), .orbit_len(olens), .path_record(recs), .status(sts)
  );

  typedef struct {
    logic [63:0] seed;
    logic        mode;
    int          len;
    logic [63:0] rec;
    logic [1:0]  st;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Samples the current cycle first, then advances; returns at the negedge where done is seen.
  task automatic wait_done(output int busy_cnt, output logic busy_at_done, output logic timed_out);
    busy_cnt = 0;
    timed_out = 1'b0;
    busy_at_done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        busy_at_done = busy;
        return;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    timed_out = 1'b1;
  endtask

  task automatic run_seed(input logic [63:0] s, input logic m,
                          output int busy_cnt, output logic busy_at_done, output logic timed_out);
    seed = s; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(busy_cnt, busy_at_done, timed_out);
  endtask

  initial begin
    int   bc;
    logic bad, to;

    vecs[0] = '{64'd27, 1'b1, 70, 64'd4616, ST_OK, 71};
    vecs[1] = '{64'd1,  1'b0, 0,  64'd1,    ST_OK, 1};
    vecs[2] = '{64'd0,  1'b0, 0,  64'd0,    ST_BAD_SEED, 1};
    vecs[3] = '{64'd6,  1'b0, 8,  64'd16,   ST_OK, 9};
    vecs[4] = '{64'd7,  1'b0, 16, 64'd52,   ST_OK, 17};
    vecs[5] = '{64'd2,  1'b0, 1,  64'd2,    ST_OK, 2};

    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; seed = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_olen", {48'd0, orbit_len}, 64'd0);
    chk("reset_rec", path_record, 64'd0);
    chk("reset_status", {62'd0, status}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Seed 27 standard on all three instances at once.
    run_seed(64'd27, 1'b0, bc, bad, to);
    chk("s27_timeout", {63'd0, to}, 64'd0);
    chk("s27_busy_cycles", bc, 64'd112);
    chk("s27_busy_at_done", {63'd0, bad}, 64'd0);
    chk("s27_olen", {48'd0, orbit_len}, 64'd111);
    chk("s27_rec", path_record, 64'd9232);
    chk("s27_status", {62'd0, status}, {62'd0, ST_OK});
    chk("ovf8_olen", {48'd0, olen8}, 64'd11);
    chk("ovf8_rec", {56'd0, rec8}, 64'd214);
    chk("ovf8_status", {62'd0, st8}, {62'd0, ST_OVF});
    chk("sat6_olen", {58'd0, olens}, 64'd63);
    chk("sat6_status", {62'd0, sts}, {62'd0, ST_OLEN_SAT});
    @(negedge clk);
    chk("s27_done_single_pulse", {63'd0, done}, 64'd0);
    chk("s27_hold_olen", {48'd0, orbit_len}, 64'd111);
    repeat (3) @(negedge clk);
    chk("s27_no_repulse", {63'd0, done}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_seed(vecs[i].seed, vecs[i].mode, bc, bad, to);
      chk($sformatf("v%0d_timeout", i), {63'd0, to}, 64'd0);
      chk($sformatf("v%0d_olen", i), {48'd0, orbit_len}, vecs[i].len);
      chk($sformatf("v%0d_rec", i), path_record, vecs[i].rec);
      chk($sformatf("v%0d_status", i), {62'd0, status}, {62'd0, vecs[i].st});
      chk($sformatf("v%0d_busy", i), bc, vecs[i].busy_cyc);
      @(negedge clk);
    end

    // Abort on the 5th busy cycle: four steps taken, no done.
    seed = 64'd27; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_olen", {48'd0, orbit_len}, 64'd4);
    chk("abort_rec", path_record, 64'd124);
    begin
      int dseen = 0;
      repeat (5) begin
        if (done) dseen++;
        @(negedge clk);
      end
      chk("abort_no_done", dseen, 64'd0);
    end

    // Reset mid-run clears everything.
    seed = 64'd27; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_olen", {48'd0, orbit_len}, 64'd0);
    chk("rst_mid_rec", path_record, 64'd0);
    chk("rst_mid_status", {62'd0, status}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: start raised in the done cycle of the previous run.
    run_seed(64'd6, 1'b0, bc, bad, to);
    chk("b2b_first_olen", {48'd0, orbit_len}, 64'd8);
    seed = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_next_cycle", {63'd0, busy}, 64'd1);
    wait_done(bc, bad, to);
    chk("b2b_timeout", {63'd0, to}, 64'd0);
    chk("b2b_busy", bc, 64'd17);
    chk("b2b_olen", {48'd0, orbit_len}, 64'd16);
    chk("b2b_rec", path_record, 64'd52);
    chk("b2b_status", {62'd0, status}, {62'd0, ST_OK});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/collatz_engine.md
# collatz_engine

Parametrised Collatz orbit engine: the next-generation replacement for the fixed 64-bit compute core behind the TT I/O shell. It accepts a seed over a start/done handshake and iterates one step per clock. It reports orbit length, path record and a status code covering overflow, length saturation and bad seed. It adds a shortcut mode ((3n+1)/2 as one step) and an abort input. The TT top-level wrapper keeps its byte-addressed register I/O and instantiates this block as its compute core.

## Interface
- `BITS`, 64: iterator / path-record width.
- `OLEN_BITS`, 16: orbit-length counter width.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high (top derives it as `!rst_n`).
- `start`  in  1  level sampled per cycle; accepted only in IDLE or DONE.
- `seed`  in  BITS  start value, latched on accepted `start`.
- `mode`  in  1  0 = standard (n/2, 3n+1), 1 = shortcut (n/2, (3n+1)/2); latched with seed.
- `abort`  in  1  in RUN: stop, go IDLE, no `done`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `orbit_len`  out  OLEN_BITS  steps taken.
- `path_record`  out  BITS  max iterator value held.
- `status`  out  2  00 ok, 01 overflow, 10 length saturated, 11 bad seed (0).

## Operation
- States: IDLE, RUN, DONE (encoding in package). Reset → IDLE. All outputs reset to 0.
- IDLE/DONE + `start`: latch seed into iter, mode; orbit_len ← 0; path_record ← seed; status ← 00; → RUN.
- RUN priority per cycle, highest first: `abort` → IDLE, outputs hold partial values; iter == 0 → DONE, status 11; iter == 1 → DONE, status 00, no step; step would overflow → DONE, status 01, iter/record unchanged; orbit_len all-ones → DONE, status 10, no step; otherwise step.
- Step: even → iter >> 1. Odd → 3n+1, or (3n+1)>>1 in shortcut mode, computed in BITS+2 bits. Overflow when the result is ≥ 2^BITS.
- Each step: orbit_len += 1. path_record ← max(path_record, next iter).
- `start` in RUN: ignored. `abort` outside RUN: ignored.
- DONE holds results until the next accepted `start`. `done` is not re-pulsed.

## Timing
- Accepted `start` at edge 0 → `busy` high from cycle 1.
- For a seed reaching 1 in L steps: `busy` high exactly L+1 cycles. `done` is high in cycle L+2, and `busy` is low in that same cycle.
- Seed 1 or 0: `busy` 1 cycle, `done` in cycle 2.
- Results are valid and stable whenever `done` is high and throughout DONE. They are updated every cycle during RUN.
- `start` asserted in the DONE cycle that pulses `done` is accepted: back-to-back runs, no idle gap.
- `reset` mid-RUN: next cycle IDLE, all outputs 0.

## Structure
- Package `collatz_pkg`: state encoding (IDLE/RUN/DONE) and status codes (ST_OK, ST_OVF, ST_OLEN_SAT, ST_BAD_SEED).
- Sub-module `collatz_step`, purely combinational, parametrised by BITS. Inputs: iter, mode. Outputs: next value, overflow flag. The FSM, counters and record register stay in `collatz_engine`.

## Test plan
- Standard: seed 27, mode 0 → orbit_len 111, path_record 9232, status 00, `busy` 112 cycles, single `done` pulse.
- Shortcut: seed 27, mode 1 → orbit_len 70, path_record 4616, status 00.
- Edge seeds: seed 1 → orbit_len 0, record 1, status 00; seed 0 → orbit_len 0, record 0, status 11.
- Overflow, BITS=8: seed 27 → orbit_len 11, path_record 214, status 01 (107 → 322 rejected).
- Saturation, OLEN_BITS=6: seed 27 → orbit_len 63, status 10.
- Control: `abort` 5 cycles into a seed-27 run → IDLE, no `done`, orbit_len 4. Then `reset` mid-run → all outputs 0. Then a back-to-back `start` on the `done` cycle → second run completes correctly.
